iod_eye_training_ctrl: RTL and testbench
========================================

Name: iod_eye_training_ctrl

Overview:
- Multi-lane receive-side training controller for the PolarFire IOD generic RX path. For each lane it sweeps the IOD input delay line and samples the eye-monitor EARLY/LATE flags at every tap.
- It finds the widest clean window, then parks the delay line at the window centre.
- Sits in fabric between the PF_IOD_GENERIC_RX lanes and the receive datapath. It replaces the fixed-delay, flag-only clock-training lane with automatic centring.

Parameters:
- NUM_LANES, 4, number of IOD lanes trained sequentially (1..16).
- NUM_TAPS, 128, delay-line taps swept per lane (2..256).
- TAP_W, 8, width of tap indices; must satisfy 2^TAP_W >= NUM_TAPS.
- SETTLE_CYCLES, 8, FAB_CLK cycles waited after each tap move or flag clear before sampling (>=1).
- SAMPLE_CYCLES, 16, cycles over which flags are OR-accumulated per tap (>=1).
- MIN_EYE, 4, minimum clean-run length (taps) for a lane to pass.

Ports:
- FAB_CLK, in, 1, fabric clock; all logic is synchronous to it.
- ARST_N, in, 1, asynchronous active-low reset.
- TRAIN_START, in, 1, single-cycle start pulse; sampled only in IDLE.
- EYE_MONITOR_EARLY, in, NUM_LANES, per-lane early flag from the IOD.
- EYE_MONITOR_LATE, in, NUM_LANES, per-lane late flag from the IOD.
- DELAY_LINE_LOAD, out, NUM_LANES, one-cycle pulse that returns the lane delay to tap 0.
- DELAY_LINE_MOVE, out, NUM_LANES, one-cycle pulse that steps the lane delay by one tap.
- DELAY_LINE_DIRECTION, out, NUM_LANES, 1 = increment; held at 1 throughout.
- EYE_MONITOR_CLEAR_FLAGS, out, NUM_LANES, one-cycle flag-clear pulse.
- TRAIN_BUSY, out, 1, high from the accepted start until DONE.
- TRAIN_DONE, out, 1, sticky high after all lanes finish; cleared by the next accepted start.
- LANE_ERROR, out, NUM_LANES, sticky per-lane fail flag.
- LANE_TAP, out, NUM_LANES*TAP_W, final parked tap per lane; lane i occupies bits [i*TAP_W +: TAP_W].

Behaviour:
- Reset values: all outputs 0, except DELAY_LINE_DIRECTION, which resets to all 1s. FSM resets to IDLE; reset is asserted asynchronously and released synchronously.
- Only the lane addressed by the internal lane index, lane_idx, pulses its strobes. All other lanes' strobes stay 0.
- FSM states:
  - IDLE: on TRAIN_START go to LOAD. Clear TRAIN_DONE, LANE_ERROR and LANE_TAP; set lane_idx=0 and TRAIN_BUSY=1.
  - LOAD: pulse DELAY_LINE_LOAD for lane_idx. Set tap=0, best_len=0, run_len=0. Go to CLEAR.
  - CLEAR: pulse EYE_MONITOR_CLEAR_FLAGS. Go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to SAMPLE.
  - SAMPLE: OR EARLY|LATE for lane_idx over SAMPLE_CYCLES into `dirty`. Then evaluate:
    - If clean: run_len++. If run_len is 0 before the increment, run_start=tap.
    - If dirty: run_len=0.
    - If the updated run_len > best_len (strictly greater, so the earliest of equal runs wins): best_len=run_len, best_start=run_start.
    - If tap==NUM_TAPS-1 go to EVAL; else go to STEP.
  - STEP: pulse DELAY_LINE_MOVE, tap++, go to CLEAR.
  - EVAL: centre = best_start + (best_len>>1), floor.
    - If best_len < MIN_EYE: set LANE_ERROR[lane_idx]=1, centre=0.
    - Go to RELOAD.
  - RELOAD: pulse DELAY_LINE_LOAD, cnt=0. Go to CENTER.
  - CENTER: while cnt<centre, pulse MOVE every 2nd cycle (pulse, gap) and cnt++. When done, write LANE_TAP[lane_idx]=centre and go to NEXT.
  - NEXT: if lane_idx==NUM_LANES-1 go to DONE; else lane_idx++ and go to LOAD.
  - DONE: TRAIN_BUSY=0, TRAIN_DONE=1, return to IDLE.
- Counters are sized by $clog2 of their maximum value plus 1. best_len and run_len are TAP_W+1 bits wide so a run of NUM_TAPS=256 does not overflow.
- TRAIN_START while BUSY is ignored.
- ARST_N mid-sweep: immediate return to IDLE, all outputs reset. The delay line is not reloaded until the next run.
- An all-clean lane yields best_start=0, best_len=NUM_TAPS, centre=NUM_TAPS/2.

Optional Feature:
- Macro: IOD_TRAIN_EYE_WIDTH_EN.
- When defined:
  - Adds output LANE_EYE_WIDTH, NUM_LANES*(TAP_W+1) bits, holding best_len per lane.
  - Written in EVAL; cleared on start and on reset.
- When undefined: the port is absent and best_len is not stored per lane.

Decomposition:
- Package iod_train_pkg:
  - FSM state enum (IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, EVAL, RELOAD, CENTER, NEXT, DONE).
  - Function for the centre computation.
  - Localparams for counter widths.
- One natural sub-module: iod_train_run_tracker. It holds the run_len/run_start/best_len/best_start update and is reusable for TX-side training.

Test Plan:
- Bench config: NUM_LANES=2, NUM_TAPS=16, SETTLE=2, SAMPLE=2, MIN_EYE=3.
- Lane0 clean on taps 4..11, lane1 clean on taps 0..15:
  - Lane0: LANE_TAP=8, exactly 15 sweep MOVEs then 8 centring MOVEs.
  - Lane1: LANE_TAP=8.
  - TRAIN_DONE=1, LANE_ERROR=0.
- Lane0 clean on 2..4 and 8..13 -> best run 8..13 (len 6), LANE_TAP=11.
- Lane0 clean on 1..4 and 9..12 (tie) -> first run wins, LANE_TAP=3.
- Lane0 always dirty -> LANE_ERROR[0]=1, LANE_TAP=0, no centring MOVEs, lane1 still trained.
- TRAIN_START pulsed during BUSY -> ignored.
- ARST_N low during lane0 SAMPLE -> all outputs 0 within the same cycle, FSM in IDLE. A fresh start then completes normally.

Source files
------------

// File: rtl/iod_train_pkg.sv
// -----------------------------------------------------------------------------
// iod_train_pkg
// Shared definitions for the IOD eye-training controller:
//   - train_state_t : controller FSM states
//   - CALC_W        : working width of the centre calculation
//   - cnt_width()   : width of a counter that must reach max_val
//   - eye_centre()  : floor centre of a window (start + len/2)
// -----------------------------------------------------------------------------
package iod_train_pkg;

   localparam int CALC_W = 16;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      CLEAR,
      SETTLE,
      SAMPLE,
      STEP,
      EVAL,
      RELOAD,
      CENTER,
      NEXT,
      DONE
   } train_state_t;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic logic [CALC_W-1:0] eye_centre(input logic [CALC_W-1:0] start,
                                                    input logic [CALC_W-1:0] len);
      return start + (len >> 1);
   endfunction

endpackage

// File: rtl/iod_train_run_tracker.sv
// -----------------------------------------------------------------------------
// iod_train_run_tracker
// Tracks the current run of clean taps and the longest run seen so far while
// a delay line is swept. A strictly-greater compare keeps the earliest of
// equal-length runs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   init        : clears all run state before a new sweep
//   update      : one evaluation for the tap currently sampled
//   dirty       : 1 if any eye-monitor flag fired on this tap
//   tap         : tap index being evaluated
//   best_len    : length of the longest clean run (TAP_W+1 bits)
//   best_start  : first tap of that run
// -----------------------------------------------------------------------------
module iod_train_run_tracker
   import iod_train_pkg::*;
#(
   parameter int TAP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             update,
   input  logic             dirty,
   input  logic [TAP_W-1:0] tap,
   output logic [TAP_W:0]   best_len,
   output logic [TAP_W-1:0] best_start
);

   logic [TAP_W:0]   run_len;
   logic [TAP_W-1:0] run_start;
   logic [TAP_W:0]   run_len_nxt;
   logic [TAP_W-1:0] run_start_nxt;

   always_comb begin
      run_len_nxt   = '0;
      run_start_nxt = run_start;
      if (!dirty) begin
         run_len_nxt = run_len + (TAP_W+1)'(1);
         if (run_len == '0) begin
            run_start_nxt = tap;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_len    <= '0;
         run_start  <= '0;
         best_len   <= '0;
         best_start <= '0;
      end else if (init) begin
         run_len    <= '0;
         run_start  <= '0;
         best_len   <= '0;
         best_start <= '0;
      end else if (update) begin
         run_len   <= run_len_nxt;
         run_start <= run_start_nxt;
         if (run_len_nxt > best_len) begin
            best_len   <= run_len_nxt;
            best_start <= run_start_nxt;
         end
      end
   end

endmodule

// File: rtl/iod_eye_training_ctrl.sv
// -----------------------------------------------------------------------------
// iod_eye_training_ctrl
// Sequential per-lane RX eye training for PF_IOD_GENERIC_RX lanes. Each lane's
// delay line is swept from tap 0 to NUM_TAPS-1; EARLY|LATE is OR-accumulated
// per tap, the widest clean window is found and the delay line is parked at
// its centre.
// Ports:
//   FAB_CLK, ARST_N          : clock, asynchronous active-low reset
//   TRAIN_START              : start pulse, honoured only when idle
//   EYE_MONITOR_EARLY/LATE   : per-lane eye-monitor flags
//   DELAY_LINE_LOAD/MOVE     : per-lane delay-line strobes (one-cycle pulses)
//   DELAY_LINE_DIRECTION     : constant increment direction
//   EYE_MONITOR_CLEAR_FLAGS  : per-lane flag-clear pulse
//   TRAIN_BUSY, TRAIN_DONE   : run status (DONE is sticky)
//   LANE_ERROR               : sticky per-lane fail (eye narrower than MIN_EYE)
//   LANE_TAP                 : parked tap per lane, lane i at [i*TAP_W +: TAP_W]
//   LANE_EYE_WIDTH           : best_len per lane, only with IOD_TRAIN_EYE_WIDTH_EN
// Optional build macro: IOD_TRAIN_EYE_WIDTH_EN
// -----------------------------------------------------------------------------
module iod_eye_training_ctrl
   import iod_train_pkg::*;
#(
   parameter int NUM_LANES     = 4,
   parameter int NUM_TAPS      = 128,
   parameter int TAP_W         = 8,
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLE_CYCLES = 16,
   parameter int MIN_EYE       = 4
) (
   input  logic                       FAB_CLK,
   input  logic                       ARST_N,
   input  logic                       TRAIN_START,
   input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
   input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
   output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
   output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
   output logic                       TRAIN_BUSY,
   output logic                       TRAIN_DONE,
   output logic [NUM_LANES-1:0]       LANE_ERROR,
   output logic [NUM_LANES*TAP_W-1:0] LANE_TAP
`ifdef IOD_TRAIN_EYE_WIDTH_EN
   ,
   output logic [NUM_LANES*(TAP_W+1)-1:0] LANE_EYE_WIDTH
`endif
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CNT_W  = cnt_width((SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES);

   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(NUM_TAPS - 1);
   localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
   localparam logic [TAP_W:0]    MIN_EYE_L   = (TAP_W+1)'(MIN_EYE);

   // Reset asserts immediately but is released only on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   // The delay line only ever steps upward.
   assign DELAY_LINE_DIRECTION = '1;

   train_state_t      state;
   logic [LANE_W-1:0] lane_idx;
   logic [TAP_W-1:0]  tap;
   logic [CNT_W-1:0]  cnt;
   logic [TAP_W-1:0]  centre;
   logic [TAP_W-1:0]  ctr_cnt;
   logic              ctr_gap;
   logic              dirty_acc;

   logic              flag_now;
   logic              sample_done;
   logic [TAP_W:0]    best_len;
   logic [TAP_W-1:0]  best_start;

   assign flag_now    = EYE_MONITOR_EARLY[lane_idx] | EYE_MONITOR_LATE[lane_idx];
   assign sample_done = (state == SAMPLE) && (cnt == SAMPLE_LAST);

   // The final sample cycle folds its live flag straight into the verdict.
   iod_train_run_tracker #(
      .TAP_W (TAP_W)
   ) u_run_tracker (
      .clk        (FAB_CLK),
      .rst_n      (rst_n),
      .init       (state == LOAD),
      .update     (sample_done),
      .dirty      (dirty_acc | flag_now),
      .tap        (tap),
      .best_len   (best_len),
      .best_start (best_start)
   );

   always_ff @(posedge FAB_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state                   <= IDLE;
         lane_idx                <= '0;
         tap                     <= '0;
         cnt                     <= '0;
         centre                  <= '0;
         ctr_cnt                 <= '0;
         ctr_gap                 <= 1'b0;
         dirty_acc               <= 1'b0;
         DELAY_LINE_LOAD         <= '0;
         DELAY_LINE_MOVE         <= '0;
         EYE_MONITOR_CLEAR_FLAGS <= '0;
         TRAIN_BUSY              <= 1'b0;
         TRAIN_DONE              <= 1'b0;
         LANE_ERROR              <= '0;
         LANE_TAP                <= '0;
`ifdef IOD_TRAIN_EYE_WIDTH_EN
         LANE_EYE_WIDTH          <= '0;
`endif
      end else begin
         DELAY_LINE_LOAD         <= '0;
         DELAY_LINE_MOVE         <= '0;
         EYE_MONITOR_CLEAR_FLAGS <= '0;

         case (state)
            IDLE: begin
               if (TRAIN_START) begin
                  TRAIN_BUSY <= 1'b1;
                  TRAIN_DONE <= 1'b0;
                  LANE_ERROR <= '0;
                  LANE_TAP   <= '0;
`ifdef IOD_TRAIN_EYE_WIDTH_EN
                  LANE_EYE_WIDTH <= '0;
`endif
                  lane_idx   <= '0;
                  state      <= LOAD;
               end
            end

            LOAD: begin
               DELAY_LINE_LOAD[lane_idx] <= 1'b1;
               tap                       <= '0;
               state                     <= CLEAR;
            end

            CLEAR: begin
               EYE_MONITOR_CLEAR_FLAGS[lane_idx] <= 1'b1;
               cnt                               <= '0;
               state                             <= SETTLE;
            end

            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt       <= '0;
                  dirty_acc <= 1'b0;
                  state     <= SAMPLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            SAMPLE: begin
               if (cnt == SAMPLE_LAST) begin
                  dirty_acc <= 1'b0;
                  state     <= (tap == TAP_LAST) ? EVAL : STEP;
               end else begin
                  dirty_acc <= dirty_acc | flag_now;
                  cnt       <= cnt + CNT_W'(1);
               end
            end

            STEP: begin
               DELAY_LINE_MOVE[lane_idx] <= 1'b1;
               tap                       <= tap + TAP_W'(1);
               state                     <= CLEAR;
            end

            EVAL: begin
               if (best_len < MIN_EYE_L) begin
                  LANE_ERROR[lane_idx] <= 1'b1;
                  centre               <= '0;
               end else begin
                  centre <= TAP_W'(eye_centre(CALC_W'(best_start), CALC_W'(best_len)));
               end
`ifdef IOD_TRAIN_EYE_WIDTH_EN
               LANE_EYE_WIDTH[lane_idx*(TAP_W+1) +: (TAP_W+1)] <= best_len;
`else
               // best_len is consumed only by the centre calculation here.
`endif
               state <= RELOAD;
            end

            RELOAD: begin
               DELAY_LINE_LOAD[lane_idx] <= 1'b1;
               ctr_cnt                   <= '0;
               ctr_gap                   <= 1'b0;
               state                     <= CENTER;
            end

            // MOVE pulses are separated by an idle cycle so the delay line
            // never sees back-to-back steps.
            CENTER: begin
               if (ctr_gap) begin
                  ctr_gap <= 1'b0;
               end else if (ctr_cnt != centre) begin
                  DELAY_LINE_MOVE[lane_idx] <= 1'b1;
                  ctr_cnt                   <= ctr_cnt + TAP_W'(1);
                  ctr_gap                   <= 1'b1;
               end else begin
                  LANE_TAP[lane_idx*TAP_W +: TAP_W] <= centre;
                  state                             <= NEXT;
               end
            end

            NEXT: begin
               if (lane_idx == LANE_LAST) begin
                  state <= DONE;
               end else begin
                  lane_idx <= lane_idx + LANE_W'(1);
                  state    <= LOAD;
               end
            end

            DONE: begin
               TRAIN_BUSY <= 1'b0;
               TRAIN_DONE <= 1'b1;
               state      <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iod_eye_training_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iod_eye_training_ctrl
// Bench for iod_eye_training_ctrl (2 lanes, 16 taps). A small IOD model tracks
// each lane's delay-line tap from LOAD/MOVE pulses and raises EARLY/LATE on
// taps outside the lane's clean map. Expected parked taps come from a
// run-enumeration model of the widest clean window.
// -----------------------------------------------------------------------------
module tb_iod_eye_training_ctrl;

   localparam int NL  = 2;
   localparam int NT  = 16;
   localparam int TW  = 4;
   localparam int SC  = 2;
   localparam int SMC = 2;
   localparam int ME  = 3;

   logic          FAB_CLK = 1'b0;
   logic          ARST_N;
   logic          TRAIN_START;
   logic [NL-1:0] EYE_MONITOR_EARLY;
   logic [NL-1:0] EYE_MONITOR_LATE;
   logic [NL-1:0] DELAY_LINE_LOAD;
   logic [NL-1:0] DELAY_LINE_MOVE;
   logic [NL-1:0] DELAY_LINE_DIRECTION;
   logic [NL-1:0] EYE_MONITOR_CLEAR_FLAGS;
   logic          TRAIN_BUSY;
   logic          TRAIN_DONE;
   logic [NL-1:0] LANE_ERROR;
   logic [NL*TW-1:0] LANE_TAP;

   int checks = 0;
   int errors = 0;

   always #5 FAB_CLK = ~FAB_CLK;

   iod_eye_training_ctrl #(
      .NUM_LANES     (NL),
      .NUM_TAPS      (NT),
      .TAP_W         (TW),
      .SETTLE_CYCLES (SC),
      .SAMPLE_CYCLES (SMC),
      .MIN_EYE       (ME)
   ) dut (
      .FAB_CLK                 (FAB_CLK),
      .ARST_N                  (ARST_N),
      .TRAIN_START             (TRAIN_START),
      .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
      .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
      .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
      .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
      .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
      .TRAIN_BUSY              (TRAIN_BUSY),
      .TRAIN_DONE              (TRAIN_DONE),
      .LANE_ERROR              (LANE_ERROR),
      .LANE_TAP                (LANE_TAP)
   );

   logic [NT-1:0] clean_map [NL];
   int  tap_model   [NL] = '{default: 0};
   int  load_cnt    [NL] = '{default: 0};
   int  sweep_moves [NL] = '{default: 0};
   int  ctr_moves   [NL] = '{default: 0};
   int  exp_tap     [NL] = '{default: 0};
   bit  exp_err     [NL] = '{default: 0};
   bit  exp_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Widest clean window: enumerate maximal runs, keep the first longest.
   function automatic void model_lane(input logic [NT-1:0] m, output int tap, output bit err);
      int best, bstart, i, j;
      best = 0; bstart = 0; i = 0;
      while (i < NT) begin
         if (m[i]) begin
            j = i;
            while (j < NT && m[j]) j++;
            if (j - i > best) begin
               best   = j - i;
               bstart = i;
            end
            i = j;
         end else begin
            i++;
         end
      end
      err = (best < ME);
      tap = err ? 0 : bstart + best / 2;
   endfunction

   // IOD delay-line model, updated mid-cycle from the registered strobes.
   always @(negedge FAB_CLK) begin
      for (int l = 0; l < NL; l++) begin
         if (DELAY_LINE_LOAD[l]) begin
            tap_model[l] = 0;
            load_cnt[l]++;
         end
         if (DELAY_LINE_MOVE[l]) begin
            tap_model[l]++;
            if (load_cnt[l] == 1) sweep_moves[l]++;
            else                  ctr_moves[l]++;
         end
      end
   end

   // Dirty taps alternate between EARLY (odd) and LATE (even).
   always_comb begin
      EYE_MONITOR_EARLY = '0;
      EYE_MONITOR_LATE  = '0;
      for (int l = 0; l < NL; l++) begin
         if (!clean_map[l][tap_model[l] % NT]) begin
            if ((tap_model[l] % 2) == 1) EYE_MONITOR_EARLY[l] = 1'b1;
            else                         EYE_MONITOR_LATE[l]  = 1'b1;
         end
      end
   end

   // Per-cycle compare against the model and structural rules.
   always @(negedge FAB_CLK) begin
      logic [NL-1:0] strobes;
      strobes = DELAY_LINE_LOAD | DELAY_LINE_MOVE | EYE_MONITOR_CLEAR_FLAGS;
      check("direction", DELAY_LINE_DIRECTION, {NL{1'b1}});
      check("strobe_single_lane", ($countones(strobes) <= 1), 1);
      if (!TRAIN_BUSY) check("strobe_when_idle", strobes, 0);
      check("busy_done_excl", TRAIN_BUSY & TRAIN_DONE, 0);
      if (exp_valid && TRAIN_DONE) begin
         for (int l = 0; l < NL; l++) begin
            check($sformatf("model_lane_tap%0d", l), LANE_TAP[l*TW +: TW], exp_tap[l]);
            check($sformatf("model_lane_err%0d", l), LANE_ERROR[l], exp_err[l]);
         end
      end
   end

   task automatic run_case(input string name, input logic [NT-1:0] m0, input logic [NT-1:0] m1,
                           input int lit_tap0, input int lit_tap1, input logic [1:0] lit_err,
                           input bit spurious);
      int mt, cyc;
      bit me;
      int lit_tap [NL];
      lit_tap[0] = lit_tap0;
      lit_tap[1] = lit_tap1;
      @(posedge FAB_CLK); #1;
      exp_valid    = 1'b0;
      clean_map[0] = m0;
      clean_map[1] = m1;
      for (int l = 0; l < NL; l++) begin
         model_lane(clean_map[l], mt, me);
         exp_tap[l]     = mt;
         exp_err[l]     = me;
         load_cnt[l]    = 0;
         sweep_moves[l] = 0;
         ctr_moves[l]   = 0;
         check({name, "_pin_model_tap"}, exp_tap[l], lit_tap[l]);
         check({name, "_pin_model_err"}, exp_err[l], lit_err[l]);
      end
      TRAIN_START = 1'b1;
      @(posedge FAB_CLK); #1;
      TRAIN_START = 1'b0;
      check({name, "_busy_at_start"}, TRAIN_BUSY, 1);
      check({name, "_done_cleared"}, TRAIN_DONE, 0);
      exp_valid = 1'b1;
      if (spurious) begin
         repeat (20) @(posedge FAB_CLK);
         #1 TRAIN_START = 1'b1;
         @(posedge FAB_CLK); #1;
         TRAIN_START = 1'b0;
         check({name, "_busy_after_spurious"}, TRAIN_BUSY, 1);
      end
      cyc = 0;
      while (!TRAIN_DONE && cyc < 3000) begin
         @(negedge FAB_CLK);
         cyc++;
      end
      check({name, "_done_reached"}, TRAIN_DONE, 1);
      @(negedge FAB_CLK);
      check({name, "_busy_end"}, TRAIN_BUSY, 0);
      check({name, "_lane_error"}, LANE_ERROR, lit_err);
      for (int l = 0; l < NL; l++) begin
         check($sformatf("%s_lane_tap%0d", name, l), LANE_TAP[l*TW +: TW], lit_tap[l]);
         check($sformatf("%s_loads%0d", name, l), load_cnt[l], 2);
         check($sformatf("%s_sweep_moves%0d", name, l), sweep_moves[l], NT - 1);
         check($sformatf("%s_centre_moves%0d", name, l), ctr_moves[l], lit_tap[l]);
      end
   endtask

   initial begin
      int seen, cyc;
      ARST_N       = 1'b0;
      TRAIN_START  = 1'b0;
      clean_map[0] = '1;
      clean_map[1] = '1;
      repeat (3) @(negedge FAB_CLK);
      check("rst_busy", TRAIN_BUSY, 0);
      check("rst_done", TRAIN_DONE, 0);
      check("rst_error", LANE_ERROR, 0);
      check("rst_tap", LANE_TAP, 0);
      check("rst_strobes", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS}, 0);
      check("rst_direction", DELAY_LINE_DIRECTION, {NL{1'b1}});
      ARST_N = 1'b1;
      repeat (5) @(negedge FAB_CLK);

      // Single window plus all-clean lane; a start pulse mid-run is ignored.
      run_case("centre", 16'h0FF0, 16'hFFFF, 8, 8, 2'b00, 1'b1);
      // Wider second window wins; lane1 window exactly MIN_EYE wide.
      run_case("widest", 16'h3F1C, 16'h00E0, 11, 6, 2'b00, 1'b0);
      // Equal windows: earliest wins; lane1 too narrow.
      run_case("tie", 16'h1E1E, 16'h0003, 3, 0, 2'b10, 1'b0);
      // Lane0 closed eye; lane1 window touching the last tap.
      run_case("closed", 16'h0000, 16'hE000, 0, 14, 2'b01, 1'b0);

      // Asynchronous reset during lane0 sampling.
      @(posedge FAB_CLK); #1;
      TRAIN_START = 1'b1;
      @(posedge FAB_CLK); #1;
      TRAIN_START = 1'b0;
      seen = 0;
      cyc  = 0;
      while (seen < 3 && cyc < 500) begin
         @(negedge FAB_CLK);
         cyc++;
         if (EYE_MONITOR_CLEAR_FLAGS[0]) seen++;
      end
      check("arst_reached_sweep", seen, 3);
      @(negedge FAB_CLK);
      @(negedge FAB_CLK);
      exp_valid = 1'b0;
      #1 ARST_N = 1'b0;
      #1;
      check("arst_busy", TRAIN_BUSY, 0);
      check("arst_done", TRAIN_DONE, 0);
      check("arst_error", LANE_ERROR, 0);
      check("arst_tap", LANE_TAP, 0);
      check("arst_strobes", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS}, 0);
      @(negedge FAB_CLK);
      ARST_N = 1'b1;
      repeat (10) @(negedge FAB_CLK);
      check("arst_idle_busy", TRAIN_BUSY, 0);
      check("arst_idle_done", TRAIN_DONE, 0);

      run_case("after_rst", 16'h0FF0, 16'hFFFF, 8, 8, 2'b00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
